// File: rtl/ddr_burst_arbiter_pkg.sv
// Shared definitions for the DDR burst-port arbiter: FSM encoding, default
// widths and the DDR address map used by the requesting channels.
package ddr_burst_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_RD   = 3'd2,
    ST_WR   = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  localparam int LEN_W_DEF  = 10;
  localparam int ADDR_W_DEF = 28;

  // Start of each client's region in DDR
  localparam logic [ADDR_W_DEF-1:0] ADDR_ISA      = 28'h0000000;
  localparam logic [ADDR_W_DEF-1:0] ADDR_DATA     = 28'h0008000;
  localparam logic [ADDR_W_DEF-1:0] ADDR_INT_INS  = 28'h0060000;
  localparam logic [ADDR_W_DEF-1:0] ADDR_INT_ADDR = 28'h0070000;

endpackage

// File: rtl/ddr_burst_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr_i,
// wrapping at NUM_CH. Tying ptr_i to zero gives fixed priority.
module ddr_burst_arbiter_rr_arbiter #(
  parameter int NUM_CH = 4,
  parameter int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [PTR_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o
);

  always_comb begin
    logic found;
    int   idx;
    // NOTE: every variable written here gets a value before any branch, so no latch is inferred.
    grant_o = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = (int'(ptr_i) + k) % NUM_CH;
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// Multi-channel front end to the DDR controller burst port: arbitrates one
// read or write burst at a time and steers data to/from the granted channel.
module ddr_burst_arbiter
  import ddr_burst_arbiter_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int CH_DATA_W      = 32,
  parameter int LEN_W          = LEN_W_DEF,
  parameter bit RR_EN          = 1'b1
) (
  input  logic                               mem_clk,
  input  logic                               rst,
  input  logic [NUM_CH-1:0]                  ch_req,
  input  logic [NUM_CH-1:0]                  ch_wr,
  input  logic [NUM_CH*DDR_ADDR_WIDTH-1:0]   ch_addr,
  input  logic [NUM_CH*LEN_W-1:0]            ch_len,
  input  logic [NUM_CH*CH_DATA_W-1:0]        ch_wdata,
  output logic [NUM_CH-1:0]                  ch_grant,
  output logic [NUM_CH-1:0]                  ch_wack,
  output logic [CH_DATA_W-1:0]               ch_rdata,
  output logic [NUM_CH-1:0]                  ch_rvalid,
  output logic [LEN_W-1:0]                   ch_beat_cnt,
  output logic [NUM_CH-1:0]                  ch_done,
  output logic                               rd_burst_req,
  output logic                               wr_burst_req,
  output logic [LEN_W-1:0]                   rd_burst_len,
  output logic [LEN_W-1:0]                   wr_burst_len,
  output logic [DDR_ADDR_WIDTH-1:0]          rd_burst_addr,
  output logic [DDR_ADDR_WIDTH-1:0]          wr_burst_addr,
  input  logic                               rd_burst_data_valid,
  input  logic                               wr_burst_data_req,
  input  logic                               rd_burst_finish,
  input  logic                               wr_burst_finish,
  input  logic [DDR_DATA_WIDTH-1:0]          rd_burst_data,
  output logic [DDR_DATA_WIDTH-1:0]          wr_burst_data
);

  localparam int PTR_W = $clog2(NUM_CH);

  state_e                    state_q, state_d;
  logic [NUM_CH-1:0]         grant_q, grant_d;
  logic [DDR_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]          len_q, len_d;
  logic [LEN_W-1:0]          cnt_q, cnt_d;
  logic [PTR_W-1:0]          ptr_q, ptr_d;
  logic                      rd_req_q, rd_req_d;
  logic                      wr_req_q, wr_req_d;
  logic [CH_DATA_W-1:0]      rdata_q, rdata_d;
  logic [NUM_CH-1:0]         rvalid_q, rvalid_d;

  logic [NUM_CH-1:0]         win;
  logic [PTR_W-1:0]          arb_ptr;
  logic [DDR_ADDR_WIDTH-1:0] win_addr;
  logic [LEN_W-1:0]          win_len;
  logic                      win_wr;
  logic [PTR_W-1:0]          gidx;
  logic [PTR_W-1:0]          next_ptr;
  logic [CH_DATA_W-1:0]      gr_wdata;

  assign arb_ptr = RR_EN ? ptr_q : '0;

  ddr_burst_arbiter_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PTR_W  (PTR_W)
  ) u_arb (
    .req_i   (ch_req),
    .ptr_i   (arb_ptr),
    .grant_o (win)
  );

  // Burst descriptor of the arbitration winner
  always_comb begin
    win_addr = '0;
    win_len  = '0;
    win_wr   = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win[i]) begin
        win_addr = ch_addr[i*DDR_ADDR_WIDTH +: DDR_ADDR_WIDTH];
        win_len  = ch_len[i*LEN_W +: LEN_W];
        win_wr   = ch_wr[i];
      end
    end
  end

  always_comb begin
    gidx     = '0;
    gr_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_q[i]) begin
        gidx     = PTR_W'(i);
        gr_wdata = ch_wdata[i*CH_DATA_W +: CH_DATA_W];
      end
    end
  end

  assign next_ptr = (gidx == PTR_W'(NUM_CH - 1)) ? '0 : gidx + 1'b1;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    rd_req_d = rd_req_q;
    wr_req_d = wr_req_q;
    rdata_d  = rdata_q;
    rvalid_d = '0;
    unique case (state_q)
      ST_IDLE: if (|ch_req) state_d = ST_ARB;
      ST_ARB: begin
        if (|win) begin
          grant_d = win;
          addr_d  = win_addr;
          len_d   = win_len;
          cnt_d   = '0;
          if (win_len == '0) begin
            state_d = ST_FIN;
          end else if (win_wr) begin
            state_d  = ST_WR;
            wr_req_d = 1'b1;
          end else begin
            state_d  = ST_RD;
            rd_req_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD: begin
        if (rd_burst_data_valid) begin
          rdata_d  = rd_burst_data[CH_DATA_W-1:0];
          rvalid_d = grant_q;
          if (cnt_q < len_q) cnt_d = cnt_q + 1'b1;
        end
        // Finish is authoritative even if fewer or more beats than len arrived
        if (rd_burst_finish) begin
          rd_req_d = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_WR: begin
        if (wr_burst_data_req && (cnt_q < len_q)) cnt_d = cnt_q + 1'b1;
        if (wr_burst_finish) begin
          wr_req_d = 1'b0;
          state_d  = ST_FIN;
        end
      end
      ST_FIN: begin
        grant_d = '0;
        cnt_d   = '0;
        ptr_d   = next_ptr;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge mem_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      ptr_q    <= '0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      rd_req_q <= rd_req_d;
      wr_req_q <= wr_req_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign ch_grant      = grant_q;
  assign ch_done       = (state_q == ST_FIN) ? grant_q : '0;
  assign ch_wack       = (state_q == ST_WR && wr_burst_data_req) ? grant_q : '0;
  assign ch_rdata      = rdata_q;
  assign ch_rvalid     = rvalid_q;
  assign ch_beat_cnt   = cnt_q;
  assign rd_burst_req  = rd_req_q;
  assign wr_burst_req  = wr_req_q;
  assign rd_burst_len  = len_q;
  assign wr_burst_len  = len_q;
  assign rd_burst_addr = addr_q;
  assign wr_burst_addr = addr_q;

  always_comb begin
    wr_burst_data                = '0;
    wr_burst_data[CH_DATA_W-1:0] = gr_wdata;
  end

  // Read-data bits above the channel width are deliberately dropped
  if (DDR_DATA_WIDTH > CH_DATA_W) begin : g_rd_hi
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_burst_data[DDR_DATA_WIDTH-1:CH_DATA_W];
  end

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter: arbitration table, directed burst
// corner cases and randomized bursts against a behavioural model.
module tb_ddr_burst_arbiter;
  import ddr_burst_arbiter_pkg::*;

  localparam int NCH = 4;
  localparam int AW  = 28;
  localparam int DW  = 128;
  localparam int CW  = 32;
  localparam int LW  = 10;

  logic              mem_clk, rst;
  logic [NCH-1:0]    ch_req, ch_wr;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*LW-1:0] ch_len;
  logic [NCH*CW-1:0] ch_wdata;
  logic              rd_burst_data_valid, wr_burst_data_req, rd_burst_finish, wr_burst_finish;
  logic [DW-1:0]     rd_burst_data;

  logic [NCH-1:0] ch_grant, ch_wack, ch_rvalid, ch_done;
  logic [CW-1:0]  ch_rdata;
  logic [LW-1:0]  ch_beat_cnt, rd_burst_len, wr_burst_len;
  logic           rd_burst_req, wr_burst_req;
  logic [AW-1:0]  rd_burst_addr, wr_burst_addr;
  logic [DW-1:0]  wr_burst_data;

  logic [NCH-1:0] fp_grant, fp_wack, fp_rvalid, fp_done;
  logic [CW-1:0]  fp_rdata;
  logic [LW-1:0]  fp_beat_cnt, fp_rd_len, fp_wr_len;
  logic           fp_rd_req, fp_wr_req;
  logic [AW-1:0]  fp_rd_addr, fp_wr_addr;
  logic [DW-1:0]  fp_wr_data;

  bit            cfg_wr    [NCH];
  logic [LW-1:0] cfg_len   [NCH];
  logic [AW-1:0] cfg_addr  [NCH];
  logic [CW-1:0] cfg_wdata [NCH];

  int n_checks = 0, n_fail = 0;
  int rv_tot = 0, wack_tot = 0, done_tot = 0, both_hi = 0;
  int ptr_m = 0;

  ddr_burst_arbiter #(.NUM_CH(NCH), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW),
                      .CH_DATA_W(CW), .LEN_W(LW), .RR_EN(1'b1)) dut (
    .mem_clk(mem_clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr),
    .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_grant(ch_grant), .ch_wack(ch_wack),
    .ch_rdata(ch_rdata), .ch_rvalid(ch_rvalid), .ch_beat_cnt(ch_beat_cnt), .ch_done(ch_done),
    .rd_burst_req(rd_burst_req), .wr_burst_req(wr_burst_req), .rd_burst_len(rd_burst_len),
    .wr_burst_len(wr_burst_len), .rd_burst_addr(rd_burst_addr), .wr_burst_addr(wr_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .rd_burst_data(rd_burst_data), .wr_burst_data(wr_burst_data)
  );

  ddr_burst_arbiter #(.NUM_CH(NCH), .DDR_DATA_WIDTH(DW), .DDR_ADDR_WIDTH(AW),
                      .CH_DATA_W(CW), .LEN_W(LW), .RR_EN(1'b0)) dut_fp (
    .mem_clk(mem_clk), .rst(rst), .ch_req(ch_req), .ch_wr(ch_wr), .ch_addr(ch_addr),
    .ch_len(ch_len), .ch_wdata(ch_wdata), .ch_grant(fp_grant), .ch_wack(fp_wack),
    .ch_rdata(fp_rdata), .ch_rvalid(fp_rvalid), .ch_beat_cnt(fp_beat_cnt), .ch_done(fp_done),
    .rd_burst_req(fp_rd_req), .wr_burst_req(fp_wr_req), .rd_burst_len(fp_rd_len),
    .wr_burst_len(fp_wr_len), .rd_burst_addr(fp_rd_addr), .wr_burst_addr(fp_wr_addr),
    .rd_burst_data_valid(rd_burst_data_valid), .wr_burst_data_req(wr_burst_data_req),
    .rd_burst_finish(rd_burst_finish), .wr_burst_finish(wr_burst_finish),
    .rd_burst_data(rd_burst_data), .wr_burst_data(fp_wr_data)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      ch_wr[i]             = cfg_wr[i];
      ch_addr[i*AW +: AW]  = cfg_addr[i];
      ch_len[i*LW +: LW]   = cfg_len[i];
      ch_wdata[i*CW +: CW] = cfg_wdata[i];
    end
  end

  // Pulse counters sampled mid-cycle, away from the active edge
  always @(negedge mem_clk) begin
    if (!rst) begin
      rv_tot   += $countones(ch_rvalid);
      wack_tot += $countones(ch_wack);
      done_tot += $countones(ch_done);
      if (rd_burst_req && wr_burst_req) both_hi++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge mem_clk);
    #1;
  endtask

  // Round-robin rule: first requester at or after the pointer, wrapping
  function automatic int model_pick(input logic [NCH-1:0] m);
    for (int k = 0; k < NCH; k++)
      if (m[(ptr_m + k) % NCH]) return (ptr_m + k) % NCH;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [NCH-1:0] v);
    for (int i = 0; i < NCH; i++) if (v[i]) return i;
    return 0;
  endfunction

  // One full transaction; beats_in < 0 picks a random beat count.
  task automatic do_txn(input logic [NCH-1:0] mask, input int beats_in, input bit fin_last,
                        input int drop_at);
    int w, len, beats, exp_cnt, rv0, wk0, dn0;
    logic [NCH-1:0] wexp;
    logic [DW-1:0]  rd_word;
    bit is_wr, fin;
    w       = model_pick(mask);
    wexp    = NCH'(1) << w;
    len     = int'(cfg_len[w]);
    is_wr   = cfg_wr[w];
    beats   = (beats_in < 0) ? int'($urandom_range(0, len + 2)) : beats_in;
    exp_cnt = (beats < len) ? beats : len;
    rv0 = rv_tot; wk0 = wack_tot; dn0 = done_tot;
    ch_req = mask;
    cyc(); cyc();
    check("grant", ch_grant, wexp);
    if (len == 0) begin
      check("len0_done", ch_done, wexp);
      check("len0_no_burst", {rd_burst_req, wr_burst_req}, 2'b00);
      beats = 0;
    end else begin
      check("rd_req", rd_burst_req, !is_wr);
      check("wr_req", wr_burst_req, is_wr);
      check("burst_addr", is_wr ? wr_burst_addr : rd_burst_addr, cfg_addr[w]);
      check("burst_len", is_wr ? wr_burst_len : rd_burst_len, cfg_len[w]);
      for (int b = 0; b < beats; b++) begin
        if ($urandom_range(0, 3) == 0) cyc();
        if (b == drop_at) ch_req = '0;
        fin = fin_last && (b == beats - 1);
        if (is_wr) begin
          wr_burst_data_req = 1'b1;
          wr_burst_finish   = fin;
          #1;
          check("wack", ch_wack, wexp);
          check("wr_data", wr_burst_data, cfg_wdata[w]);
          cyc();
          wr_burst_data_req = 1'b0;
          wr_burst_finish   = 1'b0;
          cfg_wdata[w]      = $urandom();
        end else begin
          rd_word = {$urandom(), $urandom(), $urandom(), $urandom()};
          rd_burst_data       = rd_word;
          rd_burst_data_valid = 1'b1;
          rd_burst_finish     = fin;
          cyc();
          rd_burst_data_valid = 1'b0;
          rd_burst_finish     = 1'b0;
          check("rvalid", ch_rvalid, wexp);
          check("rdata", ch_rdata, rd_word[CW-1:0]);
        end
      end
      if (!(fin_last && beats > 0)) begin
        if (is_wr) wr_burst_finish = 1'b1;
        else rd_burst_finish = 1'b1;
        cyc();
        wr_burst_finish = 1'b0;
        rd_burst_finish = 1'b0;
      end
      check("done", ch_done, wexp);
      check("beat_cnt", ch_beat_cnt, exp_cnt);
      check("burst_req_dropped", {rd_burst_req, wr_burst_req}, 2'b00);
    end
    ch_req = '0;
    cyc();
    check("grant_clr", ch_grant, '0);
    check("done_pulses", done_tot - dn0, 1);
    check("rvalid_pulses", rv_tot - rv0, is_wr ? 0 : beats);
    check("wack_pulses", wack_tot - wk0, is_wr ? beats : 0);
    ptr_m = (w + 1) % NCH;
  endtask

  typedef struct {
    logic [NCH-1:0] req;
    logic [NCH-1:0] g_rr;
    logic [NCH-1:0] g_fp;
  } arb_vec_t;

  arb_vec_t tbl [10];

  initial begin
    tbl[0] = '{4'b1111, 4'b0001, 4'b0001};
    tbl[1] = '{4'b1111, 4'b0010, 4'b0001};
    tbl[2] = '{4'b1111, 4'b0100, 4'b0001};
    tbl[3] = '{4'b1111, 4'b1000, 4'b0001};
    tbl[4] = '{4'b1111, 4'b0001, 4'b0001};
    tbl[5] = '{4'b0101, 4'b0100, 4'b0001};
    tbl[6] = '{4'b0011, 4'b0001, 4'b0001};
    tbl[7] = '{4'b1100, 4'b0100, 4'b0100};
    tbl[8] = '{4'b1010, 4'b1000, 4'b0010};
    tbl[9] = '{4'b0110, 4'b0010, 4'b0010};

    for (int i = 0; i < NCH; i++) begin
      cfg_wr[i] = 1'b0; cfg_len[i] = '0; cfg_addr[i] = '0; cfg_wdata[i] = '0;
    end
    ch_req = '0;
    rd_burst_data_valid = 1'b0; wr_burst_data_req = 1'b0;
    rd_burst_finish = 1'b0; wr_burst_finish = 1'b0; rd_burst_data = '0;
    rst = 1'b1;
    #2;
    check("rst_grant", ch_grant, '0);
    check("rst_burst_req", {rd_burst_req, wr_burst_req}, 2'b00);
    check("rst_cnt", ch_beat_cnt, '0);
    check("rst_misc", {ch_done, ch_rvalid, ch_wack, ch_rdata}, '0);
    cyc(); cyc();
    rst = 1'b0;
    cyc();

    // Arbitration order with zero-length bursts, RR and fixed-priority side by side
    for (int i = 0; i < 10; i++) begin
      ch_req = tbl[i].req;
      cyc(); cyc();
      check($sformatf("arb%0d_rr", i), ch_grant, tbl[i].g_rr);
      check($sformatf("arb%0d_fp", i), fp_grant, tbl[i].g_fp);
      check($sformatf("arb%0d_done", i), ch_done, tbl[i].g_rr);
      check($sformatf("arb%0d_noburst", i), {rd_burst_req, wr_burst_req, fp_rd_req, fp_wr_req}, 4'b0);
      ch_req = '0;
      cyc();
      ptr_m = (onehot_idx(tbl[i].g_rr) + 1) % NCH;
    end

    // Single read, ch1, 17 beats
    cfg_wr[1] = 1'b0; cfg_len[1] = 10'd17; cfg_addr[1] = ADDR_DATA;
    do_txn(4'b0010, 17, 1'b0, -1);

    // Single write, ch0, 128 beats with data_req gaps
    cfg_wr[0] = 1'b1; cfg_len[0] = 10'd128; cfg_addr[0] = ADDR_ISA; cfg_wdata[0] = 32'hCAFE_0001;
    do_txn(4'b0001, 128, 1'b1, -1);

    // Zero-length burst on ch2
    cfg_wr[2] = 1'b0; cfg_len[2] = '0;
    do_txn(4'b0100, 0, 1'b0, -1);

    // Request dropped mid write burst
    cfg_wr[2] = 1'b1; cfg_len[2] = 10'd6; cfg_addr[2] = ADDR_INT_ADDR; cfg_wdata[2] = 32'h1234_5678;
    do_txn(4'b0100, 6, 1'b0, 2);

    // Reset in the middle of a read burst
    cfg_wr[3] = 1'b0; cfg_len[3] = 10'd10; cfg_addr[3] = ADDR_INT_INS;
    ch_req = 4'b1000;
    cyc(); cyc();
    check("rst_mid_grant", ch_grant, 4'b1000);
    for (int b = 0; b < 5; b++) begin
      rd_burst_data = {4{$urandom()}};
      rd_burst_data_valid = 1'b1;
      cyc();
      rd_burst_data_valid = 1'b0;
    end
    check("rst_mid_cnt5", ch_beat_cnt, 10'd5);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_grant0", ch_grant, '0);
    check("rst_mid_cnt0", ch_beat_cnt, '0);
    check("rst_mid_req0", {rd_burst_req, wr_burst_req, rd_burst_addr, rd_burst_len}, '0);
    check("rst_mid_misc0", {ch_done, ch_rvalid, ch_wack, ch_rdata}, '0);
    check("rst_mid_wdata0", wr_burst_data, '0);
    ch_req = '0;
    cyc(); cyc();
    rst = 1'b0;
    ptr_m = 0;
    cyc();
    do_txn(4'b1000, 4, 1'b1, -1);

    // Randomized bursts against the model
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NCH; i++) begin
        cfg_wr[i]    = 1'($urandom_range(0, 1));
        cfg_len[i]   = LW'($urandom_range(0, 12));
        cfg_addr[i]  = AW'($urandom());
        cfg_wdata[i] = $urandom();
      end
      do_txn(NCH'($urandom_range(1, 15)), -1, 1'($urandom_range(0, 1)), -1);
    end

    check("rd_wr_req_exclusive", both_hi, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
